// File: rtl/uart_sim_pkg.sv
// Shared types and helpers for the simulation-harness UART blocks.
// Receiver FSM states, data width and a pointer-width helper.
package uart_sim_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  // Never returns less than 1 so a 2-entry FIFO still gets a real index bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_sim_fifo.sv
// Generic fall-through FIFO: the head entry is presented on a register,
// so data_o/empty_o never depend combinationally on pop_i.
module uart_sim_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] data_o
);
  import uart_sim_pkg::*;

  localparam int AW = clog2_min1(DEPTH);
  localparam int PW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gBadDepth
    $error("uart_sim_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [WIDTH-1:0] r_head;
  logic [PW-1:0]    w_count;
  logic [PW-1:0]    w_rptrInc;
  logic             w_doPush;
  logic             w_doPop;
  logic             w_empty;
  logic             w_full;

  assign w_count   = r_wptr - r_rptr;
  assign w_rptrInc = r_rptr + 1'b1;
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == PW'(DEPTH));
  // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
  assign w_doPop   = pop_i && !w_empty;
  assign w_doPush  = push_i && (!w_full || w_doPop);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wptr[AW-1:0]] <= data_i;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_doPop) r_rptr <= w_rptrInc;
    end
  end

  // Head register: loads the next entry, or the incoming byte when it becomes the head.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_head <= '0;
    end else if (w_empty) begin
      if (w_doPush) r_head <= data_i;
    end else if (w_doPop) begin
      if (w_count != PW'(1)) r_head <= r_mem[w_rptrInc[AW-1:0]];
      else if (w_doPush)     r_head <= data_i;
    end
  end

  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign data_o  = r_head;

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver for the simulation harness: samples the core's TX line,
// queues decoded bytes in a fall-through FIFO and flags framing/overrun errors.
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  input  logic       err_clr_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);
  import uart_sim_pkg::*;

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF - 1);
  localparam logic [2:0]       LAST_IDX = 3'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : gBadClks
    $error("uart_rx_monitor: CLKS_PER_BIT must be at least 4");
  end

  logic                      r_sync1;
  logic                      r_sync2;
  rx_state_e                 r_state;
  rx_state_e                 w_stateNxt;
  logic [CNT_W-1:0]          r_bitCnt;
  logic [CNT_W-1:0]          w_bitCntNxt;
  logic [2:0]                r_idx;
  logic [2:0]                w_idxNxt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shiftNxt;
  logic                      r_busy;
  logic                      r_frameErr;
  logic                      r_overrun;
  logic                      w_push;
  logic                      w_frameSet;
  logic                      w_overrunSet;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic [UART_DATA_BITS-1:0] w_head;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd_i;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= IDLE;
      r_bitCnt <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_stateNxt;
      r_bitCnt <= w_bitCntNxt;
      r_idx    <= w_idxNxt;
      r_shift  <= w_shiftNxt;
      r_busy   <= (w_stateNxt != IDLE);
    end
  end

  // Start bit is checked at its middle; every later sample lands one full bit after that.
  always_comb begin
    w_stateNxt  = r_state;
    w_bitCntNxt = r_bitCnt;
    w_idxNxt    = r_idx;
    w_shiftNxt  = r_shift;
    w_push      = 1'b0;
    w_frameSet  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!r_sync2) begin
          w_stateNxt  = START;
          w_bitCntNxt = '0;
        end
      end
      START: begin
        if (r_bitCnt == HALF_CNT) begin
          w_bitCntNxt = '0;
          w_idxNxt    = '0;
          w_stateNxt  = r_sync2 ? IDLE : DATA;
        end else begin
          w_bitCntNxt = r_bitCnt + 1'b1;
        end
      end
      DATA: begin
        if (r_bitCnt == LAST_CNT) begin
          w_shiftNxt  = {r_sync2, r_shift[UART_DATA_BITS-1:1]};
          w_bitCntNxt = '0;
          w_idxNxt    = r_idx + 1'b1;
          if (r_idx == LAST_IDX) w_stateNxt = STOP;
        end else begin
          w_bitCntNxt = r_bitCnt + 1'b1;
        end
      end
      STOP: begin
        if (r_bitCnt == LAST_CNT) begin
          w_bitCntNxt = '0;
          if (r_sync2) begin
            w_push     = 1'b1;
            w_stateNxt = IDLE;
          end else begin
            w_frameSet = 1'b1;
            w_stateNxt = WAIT_HIGH;
          end
        end else begin
          w_bitCntNxt = r_bitCnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (r_sync2) w_stateNxt = IDLE;
      end
      default: begin
        w_stateNxt  = IDLE;
        w_bitCntNxt = '0;
      end
    endcase
  end

  assign w_pop        = ready_i && !w_empty;
  assign w_overrunSet = w_push && w_full && !w_pop;

  // Sticky flags: a set event in the same cycle as a clear wins.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_frameSet)     r_frameErr <= 1'b1;
      else if (err_clr_i) r_frameErr <= 1'b0;
      if (w_overrunSet)   r_overrun  <= 1'b1;
      else if (err_clr_i) r_overrun  <= 1'b0;
    end
  end

  uart_sim_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (w_push),
    .data_i  (r_shift),
    .full_o  (w_full),
    .pop_i   (w_pop),
    .empty_o (w_empty),
    .data_o  (w_head)
  );

  assign data_o      = w_head;
  assign valid_o     = !w_empty;
  assign frame_err_o = r_frameErr;
  assign overrun_o   = r_overrun;
  assign busy_o      = r_busy;

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
- Synthesizable 8N1 UART receiver for the simulation harness. It sits on the core's uart_txd line and turns the serial stream into bytes.
- Decoded bytes go into a small fall-through FIFO with a valid/ready output, for a console logger or a scoreboard.
- It is the receiving end of the core's UART transmitter. Its counterpart (the stimulus transmitter driving uart_rxd) is a separate block.

Parameters:
- CLKS_PER_BIT, default 868: clock cycles per bit (100 MHz / 115200). Legal range is 4 or more; elaboration fails otherwise.
- FIFO_DEPTH, default 4: receive FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  reset. Asynchronous, active-low.
- rxd_i  in  1  serial line from the core's uart_txd. Asynchronous; idles high.
- data_o  out  8  byte at the FIFO head
- valid_o  out  1  FIFO not empty
- ready_i  in  1  consumer accepts data_o. A pop occurs on valid_o && ready_i.
- err_clr_i  in  1  one-cycle pulse that clears the sticky error flags
- frame_err_o  out  1  sticky: a stop bit was sampled low
- overrun_o  out  1  sticky: a byte was dropped because the FIFO was full
- busy_o  out  1  FSM is not in IDLE

Behaviour:
- Reset values:
  - Both synchronizer flops = 1; FSM = IDLE; counters = 0.
  - FIFO empty; valid_o = 0; data_o = 0.
  - frame_err_o = 0; overrun_o = 0; busy_o = 0.
  - Reset asserted mid-frame aborts the frame immediately and discards the partial byte.
- Input synchronization: rxd_i passes through 2 flops; the FSM sees only rx_s (second stage).
- Definitions:
  - HALF = CLKS_PER_BIT/2, truncated.
  - bit_cnt counts 0..CLKS_PER_BIT-1.
  - idx is the data bit index, 0..7.
- IDLE:
  - rx_s == 0 -> START, bit_cnt = 0.
- START:
  - bit_cnt increments each cycle.
  - When bit_cnt == HALF-1, sample rx_s. A 1 is a glitch -> IDLE, nothing pushed. A 0 -> DATA with bit_cnt = 0 and idx = 0.
- DATA:
  - Sample when bit_cnt == CLKS_PER_BIT-1. Shift LSB-first into the shift register and reset bit_cnt.
  - After idx 7 is sampled -> STOP.
- STOP:
  - Sample when bit_cnt == CLKS_PER_BIT-1.
  - Sampled 1: push the byte on that same edge, then -> IDLE.
  - Sampled 0: set frame_err_o, discard the byte, -> WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s == 1, then -> IDLE. A held break produces exactly one framing error.
- Latency:
  - Edge 0 is the first clock edge that samples rxd_i = 0.
  - The byte is pushed at edge 2 + HALF + 9·CLKS_PER_BIT.
  - valid_o is high in the cycle after that edge (FIFO previously empty).
  - Back-to-back frames with no idle gap are received without loss: STOP -> IDLE -> START costs zero line time at mid-bit sampling.
- FIFO:
  - Fall-through: data_o = head entry; valid_o = !empty. Both are registered state with no combinational path from ready_i.
  - Push when full and no pop in the same cycle: byte dropped, overrun_o set, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both occur, no overrun.
  - Push and pop in the same cycle while empty: only the push takes effect; valid_o rises the next cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - data_o holds its last value when the FIFO is empty (no X).
- Error flags:
  - Both are sticky and are cleared by err_clr_i.
  - If a set event and err_clr_i occur in the same cycle, set wins.
- busy_o = (state != IDLE), registered with the state.

Decomposition:
- Package uart_sim_pkg holds:
  - enum rx_state_e {IDLE, START, DATA, STOP, WAIT_HIGH}
  - localparam UART_DATA_BITS = 8
  - function clog2_min1 for pointer widths
- Sub-module uart_sim_fifo is a generic fall-through FIFO: DEPTH and WIDTH parameters, push/full, pop/empty. uart_rx_monitor instantiates one and owns the overrun logic.

Test Plan:
All scenarios use CLKS_PER_BIT = 8 and FIFO_DEPTH = 4.
1. Send 0xA5, idle line before and after.
   - valid_o rises the cycle after edge 78; data_o = 0xA5; busy_o high throughout the frame.
   - Pop with ready_i = 1 -> valid_o = 0 the next cycle.
2. Drive rxd_i low for 3 cycles, then high (glitch).
   - FSM returns to IDLE; valid_o stays 0; frame_err_o stays 0.
3. Send 0x00 with the stop bit low and hold the line low for 40 cycles.
   - frame_err_o = 1; nothing pushed; busy_o stays 1 until the line returns high.
   - Then send 0x3C -> 0x3C is received.
   - Pulse err_clr_i -> frame_err_o = 0.
4. Hold ready_i = 0; send 5 back-to-back frames 0x01..0x05.
   - FIFO holds 0x01..0x04; overrun_o = 1.
   - Draining yields exactly 0x01, 0x02, 0x03, 0x04.
5. With the FIFO full, time a pop to land on the push edge of a 6th byte 0x06.
   - overrun_o stays 0 (cleared beforehand).
   - Drain order: 0x02, 0x03, 0x04, 0x06.
6. Assert rstn_i mid-DATA during byte 0xFF.
   - All outputs return to reset values asynchronously.
   - After release, a fresh 0x5A is received correctly.
